btn_bounce_gen: RTL and testbench

//  Synthesizable mechanical-contact emulator, the driving end of the button-filter path: turns a

---
 rtl/btn_bounce_gen_pkg.sv | 27 ++
 rtl/bounce_lfsr.sv | 29 ++
 rtl/btn_bounce_gen.sv | 110 +++++++++++
 tb/tb_btn_bounce_gen.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/btn_bounce_gen_pkg.sv
// Shared definitions for the bouncy-contact emulator: FSM states, LFSR constants, width helper.
// Latency: n/a (declarations only).
// Backpressure: n/a; the emulator is paced only by its clock enable.
package btn_bounce_gen_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_BOUNCE = 1'b1
    } state_t;

    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (maximal length).
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Number of bits needed to hold the value v (at least one bit).
    function automatic int unsigned width_for(input int unsigned v);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((v >> i) != 0) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/bounce_lfsr.sv
// 16-bit Galois LFSR noise source with step enable and synchronous seed load.
// Latency: new value one clk after a cycle with en=1; load takes priority over en.
// Backpressure: none; holds its value whenever en=0.
//
// Ports: clk (clock), load (sync seed load, active high), en (advance one step),
//        lfsr[15:0] (current register value; bit 0 is the noise bit).
module bounce_lfsr
    import btn_bounce_gen_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        load,
    input  logic        en,
    output logic [15:0] lfsr
);

    // An all-zero state would lock the LFSR, so a zero seed is replaced by 1.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    always_ff @(posedge clk) begin
        if (load) begin
            lfsr <= SEED_EFF;
        end else if (en) begin
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/btn_bounce_gen.sv
// Mechanical-contact emulator: turns a clean requested level into LEN chatter samples, then settles.
// Latency: chatter starts on the first CE step after LVL_IN differs; settles LEN CE steps later.
// Backpressure: none; CE paces every register, LVL_IN is ignored while a sequence runs.
//
// Ports: CLK, RST (sync, active high), CE (clock enable), LVL_IN (clean level),
//        BTN_OUT (registered bouncy contact), BUSY (chatter in progress), DONE (1-CLK settle pulse).
// Build option: define BOUNCE_RAND_LEN_EN to add 0..2^JITTER_W-1 random CE steps of chatter
// per sequence, taken from the LFSR low bits at sequence start.
module btn_bounce_gen
    import btn_bounce_gen_pkg::*;
#(
    parameter int unsigned BOUNCE_CYCLES = 50,
    parameter logic [15:0] LFSR_SEED     = DEFAULT_SEED,
    parameter int unsigned JITTER_W      = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic CE,
    input  logic LVL_IN,
    output logic BTN_OUT,
    output logic BUSY,
    output logic DONE
);

`ifdef BOUNCE_RAND_LEN_EN
    localparam int unsigned MAX_LEN = BOUNCE_CYCLES + (32'd1 << JITTER_W) - 1;
`else
    localparam int unsigned MAX_LEN = BOUNCE_CYCLES;
    // The jitter width only matters when the random-length option is built in.
    localparam int unsigned unused_jitter_w = JITTER_W;
`endif
    localparam int unsigned CNT_W = width_for(MAX_LEN);

    state_t           state;
    logic             level;
    logic             target;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] start_cnt;
    logic [15:0]      lfsr;
    logic             lfsr_en;

    // Noise advances once per CE step spent in BOUNCE, including the settle step.
    assign lfsr_en = CE && (state == ST_BOUNCE);

    bounce_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk  (CLK),
        .load (RST),
        .en   (lfsr_en),
        .lfsr (lfsr)
    );

    // Counter load is LEN-1 so that LEN noise samples precede the settle step.
`ifdef BOUNCE_RAND_LEN_EN
    assign start_cnt = CNT_W'(BOUNCE_CYCLES - 1) + CNT_W'(lfsr[JITTER_W-1:0]);
    logic unused_lfsr_bits;
    assign unused_lfsr_bits = ^lfsr[15:JITTER_W];
`else
    assign start_cnt = CNT_W'(BOUNCE_CYCLES - 1);
    logic unused_lfsr_bits;
    assign unused_lfsr_bits = ^lfsr[15:1];
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            level   <= 1'b0;
            target  <= 1'b0;
            cnt     <= '0;
            BTN_OUT <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            // DONE is a single-CLK pulse regardless of CE.
            DONE <= 1'b0;
            if (CE) begin
                case (state)
                    ST_IDLE: begin
                        BTN_OUT <= level;
                        if (LVL_IN != level) begin
                            target  <= LVL_IN;
                            BTN_OUT <= lfsr[0];
                            cnt     <= start_cnt;
                            state   <= ST_BOUNCE;
                            BUSY    <= 1'b1;
                        end
                    end
                    ST_BOUNCE: begin
                        if (cnt != '0) begin
                            BTN_OUT <= lfsr[0];
                            cnt     <= cnt - CNT_W'(1);
                        end else begin
                            BTN_OUT <= target;
                            level   <= target;
                            DONE    <= 1'b1;
                            state   <= ST_IDLE;
                            BUSY    <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_btn_bounce_gen.sv
// Directed bench for btn_bounce_gen: reset, chatter against a seed-driven noise model,
// input changes during chatter, sparse CE, mid-sequence reset and length distribution.
module tb_btn_bounce_gen;

    localparam int          BOUNCE_CYCLES = 50;
    localparam logic [15:0] SEED          = 16'hACE1;
`ifdef BOUNCE_RAND_LEN_EN
    localparam int          LEN_MAX       = BOUNCE_CYCLES + 15;
`else
    localparam int          LEN_MAX       = BOUNCE_CYCLES;
`endif

    logic CLK;
    logic RST;
    logic CE;
    logic LVL_IN;
    logic BTN_OUT;
    logic BUSY;
    logic DONE;

    int checks = 0;
    int errors = 0;
    logic [15:0] m_lfsr;

    btn_bounce_gen #(
        .BOUNCE_CYCLES (BOUNCE_CYCLES),
        .LFSR_SEED     (SEED),
        .JITTER_W      (4)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .CE      (CE),
        .LVL_IN  (LVL_IN),
        .BTN_OUT (BTN_OUT),
        .BUSY    (BUSY),
        .DONE    (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One chatter sequence toward tgt with CE high every div CLKs. LVL_IN is inverted before
    // noise step flip_at; RST is asserted before noise step abort_at (0 disables either).
    task automatic run_seq(input logic tgt, input int div, input int flip_at, input int abort_at,
                           output int len, output int span);
        logic [15:0] m;
        int          exp_len;
        logic        last;
        int          guard;
        bit          fin;
        m       = m_lfsr;
        exp_len = BOUNCE_CYCLES;
`ifdef BOUNCE_RAND_LEN_EN
        exp_len = exp_len + int'(m[3:0]);
`endif
        LVL_IN = tgt;
        CE     = 1'b1;
        tick();
        span = 0;
        chk("start_busy", 32'(BUSY), 32'd1);
        chk("start_done", 32'(DONE), 32'd0);
        chk("noise_0", 32'(BTN_OUT), 32'(m[0]));
        last  = m[0];
        len   = 1;
        fin   = 1'b0;
        guard = 0;
        while (!fin) begin
            for (int h = 1; h < div; h++) begin
                CE = 1'b0;
                tick();
                span++;
                chk("hold_out", 32'(BTN_OUT), 32'(last));
                chk("hold_busy", 32'(BUSY), 32'd1);
                chk("hold_done", 32'(DONE), 32'd0);
            end
            if (len == flip_at) LVL_IN = ~tgt;
            if (len == abort_at) begin
                RST = 1'b1;
                CE  = 1'b1;
                tick();
                chk("abort_out", 32'(BTN_OUT), 32'd0);
                chk("abort_busy", 32'(BUSY), 32'd0);
                chk("abort_done", 32'(DONE), 32'd0);
                RST    = 1'b0;
                CE     = 1'b0;
                m_lfsr = SEED;
                return;
            end
            CE = 1'b1;
            tick();
            span++;
            guard++;
            if (DONE) begin
                m = lfsr_next(m);
                chk("settle_out", 32'(BTN_OUT), 32'(tgt));
                chk("settle_busy", 32'(BUSY), 32'd0);
                fin = 1'b1;
            end else begin
                chk("noise", 32'(BTN_OUT), 32'(m[0]));
                chk("noise_busy", 32'(BUSY), 32'd1);
                last = m[0];
                m    = lfsr_next(m);
                len++;
                if (guard > 3 * LEN_MAX) begin
                    chk("timeout_done", 32'(DONE), 32'd1);
                    fin = 1'b1;
                end
            end
        end
        chk("len", 32'(len), 32'(exp_len));
        CE = 1'b0;
        tick();
        chk("done_width", 32'(DONE), 32'd0);
        chk("post_out", 32'(BTN_OUT), 32'(tgt));
        chk("post_busy", 32'(BUSY), 32'd0);
        m_lfsr = m;
    endtask

    initial begin
        int len;
        int span;
        int lens[20];
        int distinct;
        RST    = 1'b1;
        CE     = 1'b0;
        LVL_IN = 1'b0;
        m_lfsr = SEED;

        // Reset holds everything low even with CE high and LVL_IN requesting 1.
        LVL_IN = 1'b1;
        CE     = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("rst_out", 32'(BTN_OUT), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        RST = 1'b0;

        // 0 -> 1 with CE every CLK; stays at 1 afterwards.
        run_seq(1'b1, 1, 0, 0, len, span);
        for (int i = 0; i < 3; i++) begin
            CE = 1'b1;
            tick();
            chk("idle_hold_out", 32'(BTN_OUT), 32'd1);
            chk("idle_hold_busy", 32'(BUSY), 32'd0);
        end

        // LVL_IN drops mid-chatter: first sequence still settles at 1, then a sequence to 0.
        run_seq(1'b0, 1, 0, 0, len, span);
        run_seq(1'b1, 1, 10, 0, len, span);
        chk("flip_idle_out", 32'(BTN_OUT), 32'd1);
        run_seq(1'b0, 1, 0, 0, len, span);

        // CE every 4th CLK: chatter spans 4*LEN CLKs.
        run_seq(1'b1, 4, 0, 0, len, span);
        chk("span_ce4", 32'(span), 32'(4 * len));
`ifndef BOUNCE_RAND_LEN_EN
        chk("span_ce4_abs", 32'(span), 32'd200);
`endif

        // Reset at noise step 20, then the seed pattern repeats.
        run_seq(1'b0, 1, 0, 20, len, span);
        run_seq(1'b1, 1, 0, 0, len, span);

        // 20 alternating transitions; every length within range.
        for (int i = 0; i < 20; i++) begin
            run_seq((i % 2 == 0) ? 1'b0 : 1'b1, 1, 0, 0, len, span);
            lens[i] = len;
            chk("len_min", 32'(len >= BOUNCE_CYCLES), 32'd1);
            chk("len_max", 32'(len <= LEN_MAX), 32'd1);
        end
        distinct = 0;
        for (int i = 1; i < 20; i++) begin
            if (lens[i] != lens[0]) distinct++;
        end
`ifdef BOUNCE_RAND_LEN_EN
        chk("len_varies", 32'(distinct > 0), 32'd1);
`else
        chk("len_fixed", 32'(distinct), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
